// File: rtl/regfile_dump_reader_if.sv
// Bundle of CPU-side handshake, register-file read port and dump output stream
// for regfile_dump_reader. The master modport is the dump reader's view.
interface regfile_dump_reader_if;
  logic        start;
  logic        abort;
  logic        hold_req;
  logic        hold_ack;
  logic [1:0]  reg_index;
  logic [15:0] reg_data;
  logic [15:0] dout;
  logic [1:0]  dout_idx;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  modport master (
    input  start, abort, hold_ack, reg_data, dout_ready,
    output hold_req, reg_index, dout, dout_idx, dout_valid, dout_last,
           busy, done, checksum
  );

  modport slave (
    output start, abort, hold_ack, reg_data, dout_ready,
    input  hold_req, reg_index, dout, dout_idx, dout_valid, dout_last,
           busy, done, checksum
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Freezes the CPU register file, reads GPR0..3 one per cycle and streams each
// value out on a valid/ready beat while accumulating a 16-bit checksum.
module regfile_dump_reader (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_dump_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_READ,
    S_SEND,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [15:0] dout_q;
  logic [1:0]  dout_idx_q;
  logic        dout_valid_q;
  logic        hold_req_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
      hold_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      checksum_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            checksum_q <= '0;
            hold_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_HOLD, S_READ, S_SEND: begin
          // Abort outranks ack, capture and handshake; partial checksum is kept.
          if (bus.abort) begin
            state_q      <= S_IDLE;
            dout_valid_q <= 1'b0;
            hold_req_q   <= 1'b0;
            busy_q       <= 1'b0;
          end else if (state_q == S_HOLD) begin
            if (bus.hold_ack) begin
              state_q <= S_READ;
            end
          end else if (state_q == S_READ) begin
            dout_q       <= bus.reg_data;
            dout_idx_q   <= cnt_q;
            dout_valid_q <= 1'b1;
            checksum_q   <= checksum_q + bus.reg_data;
            state_q      <= S_SEND;
          end else if (dout_valid_q && bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            if (cnt_q == 2'd3) begin
              state_q    <= S_DONE;
              hold_req_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 2'd1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          dout_valid_q <= 1'b0;
          hold_req_q   <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_index  = cnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_idx   = dout_idx_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_valid_q & (dout_idx_q == 2'd3);
  assign bus.hold_req   = hold_req_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.checksum   = checksum_q;

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  input  1  dump request, sampled in IDLE only.
REQ-004 SHALL have: abort  input  1  synchronous cancel of an in-progress dump.
REQ-005 SHALL have: hold_req  output  1  asks the CPU to suppress register-file writes.
REQ-006 SHALL have: hold_ack  input  1  CPU confirms writes are suppressed.
REQ-007 SHALL have: reg_index  output  2  drives the register-file read1 address.
REQ-008 SHALL have: reg_data  input  16  combinational read_out1 from the register file.
REQ-009 SHALL have: dout  output  16  captured register value.
REQ-010 SHALL have: dout_idx  output  2  register number of dout.
REQ-011 SHALL have: dout_valid  output  1  dout/dout_idx are valid.
REQ-012 SHALL have: dout_ready  input  1  consumer accepts the beat.
REQ-013 SHALL have: dout_last  output  1  current beat is register 3.
REQ-014 SHALL have: busy  output  1  high in any state except IDLE.
REQ-015 SHALL have: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have: checksum  output  16  running sum of dumped values.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, READ, SEND and DONE, with a 2-bit counter cnt.
REQ-018 IDLE: start=1 and abort=0 -> HOLD; cnt<=0 and checksum<=0 on the same edge.
REQ-019 HOLD: hold_req=1; hold_ack=1 at an edge -> READ; otherwise stay, with no timeout.
REQ-020 READ: reg_index=cnt; at the edge, dout<=reg_data, dout_idx<=cnt, dout_valid<=1, checksum<=checksum+reg_data (mod 2^16, carry discarded), then go to SEND. Latency is one cycle per register read.
REQ-021 SEND: dout, dout_idx and dout_valid SHALL hold stable until dout_valid&dout_ready at an edge.
REQ-022 On handshake with cnt!=3: dout_valid<=0, cnt<=cnt+1, go to READ.
REQ-023 On handshake with cnt==3: dout_valid<=0, go to DONE.
REQ-024 DONE: done=1 and hold_req=0 for exactly one cycle, then go to IDLE; checksum holds its value until the next accepted start.
REQ-025 hold_req SHALL be 1 in HOLD, READ and SEND, and 0 in IDLE and DONE.
REQ-026 dout_last SHALL equal dout_valid & (dout_idx==3).
REQ-027 reg_index SHALL equal cnt in every state; it is don't-care outside READ but driven, never X.
REQ-028 start SHALL be ignored in every state except IDLE, including DONE.
REQ-029 abort=1 in HOLD, READ or SEND SHALL go to IDLE on the next edge, clear dout_valid and hold_req, and produce no done; checksum keeps its partial value.
REQ-030 abort has priority over start, hold_ack and the dout handshake when they occur in the same cycle.
REQ-031 hold_ack SHALL be observed only in HOLD; a deassertion later in the dump has no effect.
REQ-032 dout_ready while dout_valid=0 SHALL have no effect.
REQ-033 cnt SHALL never wrap during a dump, so exactly 4 beats (idx 0,1,2,3) are produced per completed dump.

Reset
REQ-034 reset_n=0 SHALL immediately, without waiting for clk, force IDLE, cnt=0, dout=0, dout_idx=0, dout_valid=0, hold_req=0, done=0, busy=0 and checksum=0.
REQ-035 Reset asserted mid-dump SHALL abandon the dump with no done pulse; the first start after release begins a fresh dump.

Verification
REQ-036 Nominal: GPR={0x0001,0x0002,0x0003,0x0004}; start pulse; hold_ack=1 one cycle after hold_req; dout_ready=1 -> beats idx 0..3 with values 1..4; dout_last only on idx 3; done pulse; checksum=0x000A; hold_req low in the done cycle.
REQ-037 Backpressure: dout_ready=0 for 5 cycles on beat 1 -> dout=0x0002 and idx=1 held stable; no further beats; total dump 5 cycles longer.
REQ-038 Overflow: GPR all 0xFFFF -> checksum=0xFFFC.
REQ-039 Abort: abort asserted in SEND on beat 2 -> IDLE next cycle; hold_req=0; dout_valid=0; no done; checksum=0x0006 for the nominal data.
REQ-040 Async reset: reset_n pulled low between clock edges during READ -> all outputs at reset values before the next posedge.
REQ-041 Ignored start and stall: start held high throughout a dump -> exactly one dump, then a new dump starts only from IDLE; hold_ack held 0 -> remains in HOLD with busy=1 and dout_valid=0.
